// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit producing HI/LO for mult, multu, div and divu.
// Valid/ready on both sides; flush aborts any operation in flight.
module muldiv_unit #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned MUL_LAT   = 3,
    parameter bit          DIV_EARLY = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy
);

    localparam int unsigned CW = ($clog2(WIDTH + 1) > 4) ? $clog2(WIDTH + 1) : 4;

    localparam logic [1:0] OP_MULT = 2'b00;
    localparam logic [1:0] OP_DIV  = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [1:0]       r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_div_q;
    logic [WIDTH:0]   r_div_r;
    logic [WIDTH:0]   r_div_d;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    logic             w_accept;
    logic             w_to_done;
    logic             w_cnt_zero;
    logic             w_b_zero;

    logic             w_in_signed;
    logic [WIDTH-1:0] w_a_abs;
    logic [WIDTH-1:0] w_b_abs;

    logic               w_mul_signed;
    logic [2*WIDTH-1:0] w_ma;
    logic [2*WIDTH-1:0] w_mb;
    logic [2*WIDTH-1:0] w_prod;

    logic [WIDTH+1:0] w_rem_sh;
    logic [WIDTH:0]   w_rem_sub;
    logic             w_ge;

    logic             w_div_signed;
    logic             w_q_neg;
    logic             w_r_neg;
    logic [WIDTH-1:0] w_quo;
    logic [WIDTH-1:0] w_rmd;
    logic [WIDTH-1:0] w_res_hi;
    logic [WIDTH-1:0] w_res_lo;

    assign w_accept   = in_valid && (r_state == S_IDLE) && !flush;
    assign w_cnt_zero = (r_cnt == '0);
    assign w_b_zero   = (r_b == '0);

    // Two's-complement negation at WIDTH bits is exact as an unsigned
    // magnitude, including the most-negative operand (2^(WIDTH-1)).
    assign w_in_signed = (op == OP_DIV);
    assign w_a_abs = (w_in_signed && src_a[WIDTH-1]) ? ('0 - src_a) : src_a;
    assign w_b_abs = (w_in_signed && src_b[WIDTH-1]) ? ('0 - src_b) : src_b;

    assign w_mul_signed = (r_op == OP_MULT);
    assign w_ma   = {{WIDTH{w_mul_signed & r_a[WIDTH-1]}}, r_a};
    assign w_mb   = {{WIDTH{w_mul_signed & r_b[WIDTH-1]}}, r_b};
    assign w_prod = w_ma * w_mb;

    assign w_rem_sh  = {r_div_r, r_div_q[WIDTH-1]};
    assign w_ge      = (w_rem_sh >= {1'b0, r_div_d});
    assign w_rem_sub = w_rem_sh[WIDTH:0] - r_div_d;

    assign w_div_signed = (r_op == OP_DIV);
    assign w_q_neg = w_div_signed && (r_a[WIDTH-1] ^ r_b[WIDTH-1]);
    assign w_r_neg = w_div_signed && r_a[WIDTH-1];
    assign w_quo   = w_q_neg ? ('0 - r_div_q) : r_div_q;
    assign w_rmd   = w_r_neg ? ('0 - r_div_r[WIDTH-1:0]) : r_div_r[WIDTH-1:0];

    always_comb begin
        w_res_hi = w_rmd;
        w_res_lo = w_quo;
        if (r_state == S_MUL) begin
            w_res_hi = w_prod[2*WIDTH-1:WIDTH];
            w_res_lo = w_prod[WIDTH-1:0];
        end else if (w_b_zero) begin
            w_res_hi = r_a;
            w_res_lo = '1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = op[1] ? S_DIV : S_MUL;
                end
            end
            S_MUL: begin
                if (flush) begin
                    w_state_nxt = S_IDLE;
                end else if (w_cnt_zero) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DIV: begin
                if (flush) begin
                    w_state_nxt = S_IDLE;
                end else if (w_cnt_zero || (DIV_EARLY && w_b_zero)) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (flush || out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == S_IDLE);
        out_valid = (r_state == S_DONE);
        busy      = (r_state != S_IDLE);
    end

    assign w_to_done = ((r_state == S_MUL) || (r_state == S_DIV)) && (w_state_nxt == S_DONE);

    // Divide: WIDTH restoring iterations while the counter runs down, then
    // the counter-zero cycle applies the sign fixup as it moves to DONE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_op    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_cnt   <= '0;
            r_div_q <= '0;
            r_div_r <= '0;
            r_div_d <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            if (w_accept) begin
                r_op    <= op;
                r_a     <= src_a;
                r_b     <= src_b;
                r_div_q <= w_a_abs;
                r_div_r <= '0;
                r_div_d <= {1'b0, w_b_abs};
                r_cnt   <= op[1] ? CW'(WIDTH) : CW'(MUL_LAT - 1);
            end else if ((r_state == S_MUL) || (r_state == S_DIV)) begin
                if (!w_cnt_zero) begin
                    r_cnt <= r_cnt - CW'(1);
                end
                if ((r_state == S_DIV) && !w_cnt_zero) begin
                    r_div_r <= w_ge ? w_rem_sub : w_rem_sh[WIDTH:0];
                    r_div_q <= {r_div_q[WIDTH-2:0], w_ge};
                end
            end
            if (w_to_done) begin
                r_hi <= w_res_hi;
                r_lo <= w_res_lo;
            end
        end
    end

    assign hi = r_hi;
    assign lo = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: a 32-bit default instance and a 16-bit,
// MUL_LAT=1, DIV_EARLY=0 instance, each with its own expected-result queue.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;

    logic        iv_a = 1'b0, ir_a, ov_a, or_a = 1'b1, fl_a = 1'b0, busy_a;
    logic [1:0]  op_a = 2'b00;
    logic [31:0] sa_a = '0, sb_a = '0, hi_a, lo_a;

    logic        iv_b = 1'b0, ir_b, ov_b, or_b = 1'b1, fl_b = 1'b0, busy_b;
    logic [1:0]  op_b = 2'b00;
    logic [15:0] sa_b = '0, sb_b = '0, hi_b, lo_b;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int unsigned lat;
        int unsigned acc;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];

    int unsigned cyc = 0;
    int          n_chk = 0;
    int          n_pass = 0;
    bit          seen_a = 1'b0;
    bit          seen_b = 1'b0;
    int unsigned acc;

    muldiv_unit u_dut_a (
        .clk(clk), .reset(reset), .in_valid(iv_a), .in_ready(ir_a), .op(op_a),
        .src_a(sa_a), .src_b(sb_a), .flush(fl_a), .out_valid(ov_a),
        .out_ready(or_a), .hi(hi_a), .lo(lo_a), .busy(busy_a)
    );

    muldiv_unit #(.WIDTH(16), .MUL_LAT(1), .DIV_EARLY(1'b0)) u_dut_b (
        .clk(clk), .reset(reset), .in_valid(iv_b), .in_ready(ir_b), .op(op_b),
        .src_a(sa_b), .src_b(sb_b), .flush(fl_b), .out_valid(ov_b),
        .out_ready(or_b), .hi(hi_b), .lo(lo_b), .busy(busy_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (ov_a && !seen_a) begin
            seen_a = 1'b1;
            if (q_a.size() == 0) begin
                n_chk++;
                $display("FAIL spurious_a: got out_valid=1 expected out_valid=0");
            end else begin
                e = q_a.pop_front();
                chk("hi_a", hi_a, e.hi);
                chk("lo_a", lo_a, e.lo);
                chk("lat_a", cyc - e.acc, e.lat);
            end
        end
        if (!ov_a) seen_a = 1'b0;
        if (ov_b && !seen_b) begin
            seen_b = 1'b1;
            if (q_b.size() == 0) begin
                n_chk++;
                $display("FAIL spurious_b: got out_valid=1 expected out_valid=0");
            end else begin
                e = q_b.pop_front();
                chk("hi_b", {16'h0, hi_b}, e.hi);
                chk("lo_b", {16'h0, lo_b}, e.lo);
                chk("lat_b", cyc - e.acc, e.lat);
            end
        end
        if (!ov_b) seen_b = 1'b0;
    end

    task automatic send(input bit sel, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, output int unsigned acc_cyc);
        @(negedge clk);
        if (!sel) begin
            op_a = o; sa_a = a; sb_a = b; iv_a = 1'b1;
        end else begin
            op_b = o; sa_b = a[15:0]; sb_b = b[15:0]; iv_b = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        iv_a = 1'b0;
        iv_b = 1'b0;
        acc_cyc = cyc;
    endtask

    task automatic drain(input bit sel);
        bit done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (!sel) done = (q_a.size() == 0) && !ov_a;
            else      done = (q_b.size() == 0) && !ov_b;
        end
        if (!done) begin
            n_chk++;
            $display("FAIL drain_%0d: got pending result expected idle within 200 cycles", sel);
        end
    endtask

    task automatic issue(input bit sel, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] ehi,
                         input logic [31:0] elo, input int unsigned lat);
        int unsigned t;
        send(sel, o, a, b, t);
        if (!sel) q_a.push_back('{hi: ehi, lo: elo, lat: lat, acc: t});
        else      q_b.push_back('{hi: ehi, lo: elo, lat: lat, acc: t});
        drain(sel);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1);
    end

    initial begin
        @(negedge clk);
        chk("rst_out_valid", {31'h0, ov_a}, 32'h0);
        chk("rst_busy", {31'h0, busy_a}, 32'h0);
        chk("rst_hi", hi_a, 32'h0);
        chk("rst_lo", lo_a, 32'h0);
        chk("rst_busy_b", {31'h0, busy_b}, 32'h0);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", {31'h0, ir_a}, 32'h1);
        chk("rst_in_ready_b", {31'h0, ir_b}, 32'h1);

        issue(0, 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 3);
        issue(0, 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 3);
        issue(0, 2'b00, 32'h00012345, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFDB976, 3);
        issue(0, 2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 33);
        issue(0, 2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 33);
        issue(0, 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 33);
        issue(0, 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33);
        issue(0, 2'b11, 32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF, 1);
        issue(0, 2'b10, 32'hFFFFFFF0, 32'h00000000, 32'hFFFFFFF0, 32'hFFFFFFFF, 1);

        issue(1, 2'b00, 32'h8000, 32'h0002, 32'hFFFF, 32'h0000, 1);
        issue(1, 2'b01, 32'hFFFF, 32'hFFFF, 32'hFFFE, 32'h0001, 1);
        issue(1, 2'b11, 32'h1234, 32'h0000, 32'h1234, 32'hFFFF, 17);
        issue(1, 2'b10, 32'hFFF9, 32'h0002, 32'hFFFF, 32'hFFFD, 17);
        issue(1, 2'b10, 32'h8000, 32'hFFFF, 32'h0000, 32'h8000, 17);

        // Backpressure: result held in DONE, in_valid pulses ignored
        or_a = 1'b0;
        send(0, 2'b01, 32'h00010000, 32'h00010000, acc);
        q_a.push_back('{hi: 32'h1, lo: 32'h0, lat: 3, acc: acc});
        for (int i = 0; i < 10 && !ov_a; i++) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk("bp_out_valid", {31'h0, ov_a}, 32'h1);
            chk("bp_in_ready", {31'h0, ir_a}, 32'h0);
            chk("bp_hi", hi_a, 32'h1);
            chk("bp_lo", lo_a, 32'h0);
            iv_a = (i == 2);
            op_a = 2'b11;
            @(negedge clk);
        end
        iv_a = 1'b0;
        or_a = 1'b1;
        @(negedge clk);
        chk("hs_out_valid", {31'h0, ov_a}, 32'h0);
        chk("hs_in_ready", {31'h0, ir_a}, 32'h1);
        chk("hs_busy", {31'h0, busy_a}, 32'h0);

        // Flush mid-divide: back to IDLE, result regs untouched
        send(0, 2'b11, 32'd100, 32'd7, acc);
        repeat (9) @(negedge clk);
        fl_a = 1'b1;
        @(negedge clk);
        fl_a = 1'b0;
        chk("fl_busy", {31'h0, busy_a}, 32'h0);
        chk("fl_out_valid", {31'h0, ov_a}, 32'h0);
        chk("fl_in_ready", {31'h0, ir_a}, 32'h1);
        chk("fl_hi", hi_a, 32'h1);
        chk("fl_lo", lo_a, 32'h0);
        repeat (40) @(negedge clk);
        issue(0, 2'b00, 32'd3, 32'hFFFFFFFB, 32'hFFFFFFFF, 32'hFFFFFFF1, 3);

        // Flush with in_valid in IDLE: nothing accepted
        @(negedge clk);
        iv_a = 1'b1; fl_a = 1'b1; op_a = 2'b00;
        @(negedge clk);
        iv_a = 1'b0; fl_a = 1'b0;
        chk("fliv_busy", {31'h0, busy_a}, 32'h0);
        chk("fliv_in_ready", {31'h0, ir_a}, 32'h1);

        // Asynchronous reset in the middle of a divide
        send(0, 2'b10, 32'hFFFFFFF9, 32'h2, acc);
        repeat (5) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("arst_busy", {31'h0, busy_a}, 32'h0);
        chk("arst_out_valid", {31'h0, ov_a}, 32'h0);
        chk("arst_hi", hi_a, 32'h0);
        chk("arst_lo", lo_a, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("arst_in_ready", {31'h0, ir_a}, 32'h1);
        repeat (40) @(negedge clk);

        chk("sb_a_empty", q_a.size(), 32'h0);
        chk("sb_b_empty", q_b.size(), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
